replay_tx_framer: RTL
=====================

# replay_tx_framer

Transmit-side counterpart of the replay-protection receiver (`top_replay`). It accepts one plaintext byte at a time from the host. For each byte it emits a 3-byte frame on the serial byte stream: a sequence number, the payload, and a keyed tag. The receiver uses that frame to detect replayed or reordered bytes. The block sits between the host byte source and the link serializer, and its output is the receiver's `data_in`.

## Interface

Parameters:
- `SEQ_START`, default 8'h00: sequence number loaded at reset.
- `KEY`, default 8'hA5: shared tag key; must match the receiver.

Ports:
- `clk`, input, 1: single system clock, rising-edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: when low, no new byte is accepted; a frame in flight completes.
- `data_in`, input, 8: host payload byte.
- `in_valid`, input, 1: `data_in` is valid.
- `in_ready`, output, 1: the block accepts `data_in` at this edge if `in_valid` is high.
- `data_out`, output, 8: framed byte stream to the link.
- `out_valid`, output, 1: `data_out` holds a frame byte this cycle.
- `frame_start`, output, 1: high with the SEQ byte of each frame.
- `seq_wrap`, output, 1: high with the TAG byte of the frame whose sequence number is 8'hFF.

## Operation

- FSM states: IDLE, SEQ, DATA, TAG.
- Accept condition: `in_valid && in_ready` at a rising edge.
  - `data_in` is latched into the hold register.
  - The next state is SEQ.
- `in_ready` is combinational: `enable && (state == IDLE || state == TAG)`. This allows back-to-back frames with no gap.
- Each state drives registered outputs during the cycle it occupies:
  - SEQ: `data_out` = `seq`, `out_valid`=1, `frame_start`=1 → DATA.
  - DATA: `data_out` = hold register, `out_valid`=1 → TAG.
  - TAG: `data_out` = {`seq[6:0]`,`seq[7]`} ^ hold ^ `KEY`, `out_valid`=1.
    - Leaving TAG, `seq` increments modulo 256 (8'hFF → 8'h00).
    - Next state is SEQ if a new byte was accepted this edge, else IDLE.
- `seq_wrap`=1 only during the TAG cycle of the frame with `seq`=8'hFF.
- In IDLE: `out_valid`=0, `frame_start`=0, `seq_wrap`=0; `data_out` holds its last value.
- `enable` falling mid-frame: the current frame finishes all 3 bytes, then the block goes to IDLE. `seq` is preserved across `enable` low.
- Hold-register width and all tag arithmetic are 8-bit XOR only; no carries.

## Timing

- Reset (asynchronous, `reset_n` low):
  - State IDLE, `seq` = `SEQ_START`, hold register = 0.
  - `data_out`=8'h00, `out_valid`=0, `frame_start`=0, `seq_wrap`=0.
  - `in_ready` = `enable`.
- Reset asserted mid-frame aborts the frame immediately. No partial TAG is emitted, and the sequence number does not advance.
- Latency: a byte accepted at edge N appears as SEQ in cycle N+1, DATA in N+2, TAG in N+3.
- Throughput: with `in_valid` held high and `enable` high, one frame every 3 cycles and `out_valid` is continuously 1.
- `in_valid` low while `in_ready`=1: the block stays in or returns to IDLE; no bubble bytes are emitted.
- There is no downstream backpressure. The link consumes one byte per cycle whenever `out_valid`=1.

## Test plan

- Reset then single byte:
  - Stimulus: release `reset_n`, `in_valid` pulse with 8'h48.
  - Required: bytes 8'h00, 8'h48, 8'hED; `frame_start` only on the first byte; `out_valid` returns to 0.
- Back-to-back bytes:
  - Stimulus: 8'h48 then 8'h65 with `in_valid` held high.
  - Required: 6 contiguous valid bytes 00, 48, ED, 01, 65, C2; `in_ready` high only in IDLE/TAG cycles.
- Sequence wrap:
  - Stimulus: `SEQ_START`=8'hFE, send 3 bytes.
  - Required: SEQ fields FE, FF, 00; `seq_wrap`=1 only on the TAG of the FF frame.
- Enable drop mid-frame:
  - Stimulus: deassert `enable` during the DATA cycle with `in_valid` high.
  - Required: the TAG is still emitted; no further frames; `in_ready`=0. On re-enable the next SEQ continues at the previous value + 1.
- Asynchronous reset mid-frame:
  - Stimulus: pull `reset_n` low in the DATA cycle.
  - Required: all outputs clear in the same cycle without waiting for a clock edge. The next frame after release starts with SEQ = `SEQ_START`.
- Idle gaps:
  - Stimulus: random `in_valid` with gaps.
  - Required: `out_valid` is 0 in every gap. A scoreboard recomputes the tag for every frame, and the sequence numbers are strictly incrementing.

Source files
------------

// File: rtl/replay_tx_framer.sv
// replay_tx_framer
//   Transmit framer for the replay-protection link. Each accepted host byte
//   becomes a 3-byte frame on the link: SEQ, DATA, TAG, where
//   TAG = rotl1(seq) ^ payload ^ KEY.
//
// Parameters:
//   SEQ_START  sequence number loaded at reset
//   KEY        shared tag key (must match the receiver)
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   enable       gates acceptance of new bytes; a frame in flight completes
//   data_in      host payload byte
//   in_valid     data_in is valid
//   in_ready     byte is taken at this edge if in_valid is high
//   data_out     framed byte stream to the link (registered)
//   out_valid    data_out holds a frame byte this cycle
//   frame_start  high with the SEQ byte of each frame
//   seq_wrap     high with the TAG byte of the frame whose seq is 8'hFF
module replay_tx_framer #(
    parameter logic [7:0] SEQ_START = 8'h00,
    parameter logic [7:0] KEY       = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] data_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] data_out,
    output logic       out_valid,
    output logic       frame_start,
    output logic       seq_wrap
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEQ  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_TAG  = 2'd3;

    logic [1:0] state;
    logic [7:0] seq;
    logic [7:0] hold;
    logic       accept;
    logic [7:0] seq_next;
    logic [7:0] tag;

    assign in_ready = enable && (state == ST_IDLE || state == ST_TAG);
    assign accept   = in_valid && in_ready;

    // A byte accepted while leaving TAG starts a frame with the already
    // advanced sequence number, so the SEQ byte must see the incremented value.
    assign seq_next = (state == ST_TAG) ? seq + 8'd1 : seq;
    assign tag      = {seq[6:0], seq[7]} ^ hold ^ KEY;

    // Outputs are registered on entry to each state so they are valid for
    // the whole cycle the state occupies.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            seq         <= SEQ_START;
            hold        <= '0;
            data_out    <= '0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            seq_wrap    <= 1'b0;
        end else begin
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            seq_wrap    <= 1'b0;

            if (state == ST_TAG) begin
                seq <= seq + 8'd1;
            end

            case (state)
                ST_SEQ: begin
                    state     <= ST_DATA;
                    data_out  <= hold;
                    out_valid <= 1'b1;
                end
                ST_DATA: begin
                    state     <= ST_TAG;
                    data_out  <= tag;
                    out_valid <= 1'b1;
                    seq_wrap  <= (seq == 8'hFF);
                end
                default: begin  // ST_IDLE, ST_TAG
                    if (accept) begin
                        state       <= ST_SEQ;
                        hold        <= data_in;
                        data_out    <= seq_next;
                        out_valid   <= 1'b1;
                        frame_start <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
